// File: rtl/lightbike_game_ctrl_if.sv
// PS2 scan-code byte stream feeding the lightbike game controller.
interface lightbike_game_ctrl_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;

  modport master (output ps2_key_data, output ps2_key_pressed);
  modport slave  (input  ps2_key_data, input  ps2_key_pressed);
endinterface

// File: rtl/lightbike_game_ctrl.sv
// N-player lightbike round controller: PS2 key decode, crash latching, round FSM, winner.
// Define LIGHTBIKE_SCORE_EN to build the per-player saturating win counters.
module lightbike_player_lane #(
  parameter logic [1:0] INIT = 2'd0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       run_en,
  input  logic       act,
  input  logic       key_hit,
  input  logic [1:0] key_dir,
  input  logic       crash_edge,
  output logic [1:0] orient,
  output logic       alive
);
  // A crash on the same cycle as a key suppresses the turn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      orient <= INIT;
      alive  <= 1'b0;
    end else if (load) begin
      orient <= INIT;
      alive  <= act;
    end else if (run_en && alive) begin
      if (crash_edge)
        alive <= 1'b0;
      else if (key_hit && key_dir != (orient ^ 2'd2))
        orient <= key_dir;
    end
  end
endmodule

module lightbike_game_ctrl #(
  parameter int NUM_PLAYERS = 4,
  parameter logic [32*NUM_PLAYERS-1:0] KEYMAP = {8'h75,8'h74,8'h72,8'h6b, 8'h43,8'h4b,8'h42,8'h3b,
                                                 8'h2c,8'h33,8'h34,8'h2b, 8'h1d,8'h23,8'h1b,8'h1c},
  parameter logic [2*NUM_PLAYERS-1:0]  INIT_ORIENT = {2'd0,2'd2,2'd3,2'd1}
) (
  input  logic                              clock,
  input  logic                              resetn,
  lightbike_game_ctrl_if.slave              ps2,
  input  logic                              start,
  input  logic                              new_round,
  input  logic [NUM_PLAYERS-1:0]            active_mask,
  input  logic [NUM_PLAYERS-1:0]            crash,
  output logic [NUM_PLAYERS-1:0][1:0]       orient,
  output logic [NUM_PLAYERS-1:0]            alive,
  output logic                              run,
  output logic                              game_over,
  output logic [2:0]                        winner,
  output logic                              winner_valid,
  output logic [NUM_PLAYERS-1:0][3:0]       scores
);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
  state_t state;

  logic                          brk;
  logic [NUM_PLAYERS-1:0]        crash_q, crash_edge, alive_nxt, key_hit;
  logic [NUM_PLAYERS-1:0][1:0]   key_dir;
  logic                          found, over_now;
  logic [2:0]                    win_idx;

  // Keys are matched in player order so a shared code goes to the lowest index.
  always_comb begin
    key_hit = '0;
    key_dir = '0;
    found   = 1'b0;
    if (ps2.ps2_key_pressed && !brk &&
        ps2.ps2_key_data != BRK_CODE && ps2.ps2_key_data != EXT_CODE) begin
      for (int p = 0; p < NUM_PLAYERS; p++)
        for (int d = 0; d < 4; d++)
          if (!found && ps2.ps2_key_data == KEYMAP[32*p + 8*(3-d) +: 8]) begin
            key_hit[p] = 1'b1;
            key_dir[p] = 2'(d);
            found      = 1'b1;
          end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      brk     <= 1'b0;
      crash_q <= '0;
    end else begin
      crash_q <= crash;
      if (ps2.ps2_key_pressed && ps2.ps2_key_data != EXT_CODE)
        brk <= (ps2.ps2_key_data == BRK_CODE);
    end
  end

  assign crash_edge = crash & ~crash_q;
  assign alive_nxt  = alive & ~crash_edge;
  assign over_now   = (state == RUN) && ($countones(alive) <= 1);

  always_comb begin
    win_idx = '0;
    for (int p = NUM_PLAYERS-1; p >= 0; p--)
      if (alive_nxt[p]) win_idx = 3'(p);
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    lightbike_player_lane #(.INIT(INIT_ORIENT[2*p +: 2])) u_lane (
      .clock      (clock),
      .resetn     (resetn),
      .load       (state == IDLE),
      .run_en     (state == RUN),
      .act        (active_mask[p]),
      .key_hit    (key_hit[p]),
      .key_dir    (key_dir[p]),
      .crash_edge (crash_edge[p]),
      .orient     (orient[p]),
      .alive      (alive[p])
    );
  end

  // Winner is taken from the post-crash alive set of the transition cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      run          <= 1'b0;
      game_over    <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start && $countones(active_mask) >= 2) begin
            state <= RUN;
            run   <= 1'b1;
          end
        RUN:
          if (over_now) begin
            state        <= OVER;
            run          <= 1'b0;
            game_over    <= 1'b1;
            winner       <= (alive_nxt != '0) ? win_idx : 3'd0;
            winner_valid <= (alive_nxt != '0);
          end else if (!start) begin
            state <= PAUSE;
            run   <= 1'b0;
          end
        PAUSE:
          if (start) begin
            state <= RUN;
            run   <= 1'b1;
          end
        OVER:
          if (new_round) begin
            state        <= IDLE;
            game_over    <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LIGHTBIKE_SCORE_EN
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    logic [3:0] cnt;
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
        cnt <= '0;
      else if (over_now && alive_nxt != '0 && win_idx == 3'(p) && cnt != 4'hF)
        cnt <= cnt + 4'd1;
    end
    assign scores[p] = cnt;
  end
`else
  assign scores = '0;
`endif
endmodule
